// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
//
// Hazard and stall controller for a 5-stage in-order pipeline. It resolves two
// hazards:
//   * Multi-cycle EX operations (mult/div). These freeze IF, IF/ID and ID/EX,
//     and push bubbles into EX/MEM for DIV_CYCLES consecutive cycles. One DONE
//     cycle then marks the EX result as final.
//   * Load-use hazards. When the load in EX writes a register that ID reads,
//     IF and IF/ID are frozen for one cycle and a bubble goes into ID/EX.
// A multi-cycle hold takes priority over a load-use stall.
//
// Parameters
//   DIV_CYCLES    total EX hold cycles per multi-cycle op (legal 2..64)
//   RegAddrWidth  register address width
//
// Ports
//   clk, rst         clock; synchronous active-high reset
//   ReadMem_EX       EX instruction is a load
//   target_EX        EX destination register
//   raddr_1/2_ID     ID source registers
//   re_1/2_ID        ID actually reads the matching source register
//   mc_start_EX      EX instruction is multi-cycle (held while it sits in EX)
//   stall_clr        clears stall_count (takes priority over increment)
//   is_hold_*        freeze PC / IF/ID / ID/EX
//   is_rst_*         load a bubble into ID/EX / EX/MEM
//   mc_busy          multi-cycle op in progress
//   mc_done          EX result final this cycle
//   stall_count      saturating count of cycles with is_hold_IF=1
//   state_dbg        current FSM state (0=IDLE, 1=BUSY, 2=DONE), for debug
//
// All outputs are decoded from the registered state, cnt, stall_count and the
// current inputs. While rst is high, every 1-bit output is forced to 0.
// -----------------------------------------------------------------------------
module pipeline_ctrl #(
    parameter int DIV_CYCLES   = 32,
    parameter int RegAddrWidth = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ReadMem_EX,
    input  logic [RegAddrWidth-1:0] target_EX,
    input  logic [RegAddrWidth-1:0] raddr_1_ID,
    input  logic [RegAddrWidth-1:0] raddr_2_ID,
    input  logic                    re_1_ID,
    input  logic                    re_2_ID,
    input  logic                    mc_start_EX,
    input  logic                    stall_clr,
    output logic                    is_hold_IF,
    output logic                    is_hold_IF_ID,
    output logic                    is_hold_ID_EX,
    output logic                    is_rst_ID_EX,
    output logic                    is_rst_EX_MEM,
    output logic                    mc_busy,
    output logic                    mc_done,
    output logic [15:0]             stall_count,
    output logic [1:0]              state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // The IDLE cycle that sees mc_start_EX is the first hold cycle. BUSY then
    // covers the remaining DIV_CYCLES-1, counting cnt from DIV_CYCLES-2 to 0.
    localparam logic [5:0] CNT_LOAD = 6'(DIV_CYCLES - 2);

    state_t      state;
    logic [5:0]  cnt;
    logic [15:0] stall_q;

    logic mc_hold;
    logic load_use;
    logic lu_stall;

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 6'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (mc_start_EX) begin
                        state <= BUSY;
                        cnt   <= CNT_LOAD;
                    end
                end
                BUSY: begin
                    if (cnt == 6'd0) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 6'd1;
                    end
                end
                // DONE ignores mc_start_EX. The finishing instruction is still
                // in EX this cycle and must not retrigger.
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // ------------------------------------------------------- hazard decode
    assign mc_hold = !rst && (((state == IDLE) && mc_start_EX) || (state == BUSY));

    // Register 0 is hard-wired to zero, so writing it never creates a hazard.
    assign load_use = ReadMem_EX && (target_EX != '0) &&
                      ((re_1_ID && (raddr_1_ID == target_EX)) ||
                       (re_2_ID && (raddr_2_ID == target_EX)));

    // DONE must leave every hold/rst output low. So a load-use is only
    // honoured outside DONE, and only when no multi-cycle hold is active.
    assign lu_stall = !rst && !mc_hold && (state != DONE) && load_use;

    assign is_hold_IF    = mc_hold || lu_stall;
    assign is_hold_IF_ID = mc_hold || lu_stall;
    assign is_hold_ID_EX = mc_hold;
    assign is_rst_ID_EX  = lu_stall;
    assign is_rst_EX_MEM = mc_hold;
    assign mc_busy       = mc_hold;
    assign mc_done       = !rst && (state == DONE);
    assign state_dbg     = state;

    // -------------------------------------------------------- stall counter
    always_ff @(posedge clk) begin
        if (rst || stall_clr) begin
            stall_q <= 16'd0;
        end else if (is_hold_IF && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_count = stall_q;

endmodule
